// File: rtl/load_store_queue_pkg.sv
// Shared constants for the load/store queue: RoB id width, funct3
// encodings, the IO address region and the FSM state encodings.
package load_store_queue_pkg;

    localparam int ROB_SIZE_WIDTH = 4;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    // Value of addr[17:16] that marks memory-mapped IO
    localparam logic [1:0] IO_REGION = 2'b11;

    localparam logic [1:0] ST_IDLE  = 2'b00;
    localparam logic [1:0] ST_WAIT  = 2'b01;
    localparam logic [1:0] ST_DRAIN = 2'b10;

    function automatic logic is_io(input logic [1:0] region);
        return region == IO_REGION;
    endfunction

endpackage

// File: rtl/load_store_queue_if.sv
// Memory/cache port of the load/store queue. master = LSQ, slave = memory.
interface load_store_queue_if;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [1:0]  mem_size;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    modport master (output mem_req, mem_we, mem_addr, mem_size, mem_wdata,
                    input  mem_ack, mem_rdata);
    modport slave  (input  mem_req, mem_we, mem_addr, mem_size, mem_wdata,
                    output mem_ack, mem_rdata);
endinterface

// File: rtl/load_store_queue_load_align.sv
// Combinational data alignment: extends raw load data per funct3 and
// masks store data down to the access size (both right-aligned).
module load_store_queue_load_align
    import load_store_queue_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [31:0] rdata,
    input  logic [31:0] v2,
    output logic [31:0] load_val,
    output logic [31:0] store_data
);

    // Sign/zero extension of the returned load data
    always_comb begin
        case (funct3)
            F3_LB:   load_val = {{24{rdata[7]}}, rdata[7:0]};
            F3_LH:   load_val = {{16{rdata[15]}}, rdata[15:0]};
            F3_LBU:  load_val = {24'b0, rdata[7:0]};
            F3_LHU:  load_val = {16'b0, rdata[15:0]};
            F3_LW:   load_val = rdata;
            default: load_val = rdata;
        endcase
    end

    // Store data truncated to the access width
    always_comb begin
        case (funct3)
            F3_SB:   store_data = {24'b0, v2[7:0]};
            F3_SH:   store_data = {16'b0, v2[15:0]};
            F3_SW:   store_data = v2;
            default: store_data = v2;
        endcase
    end

endmodule

// File: rtl/load_store_queue.sv
// In-order load/store queue. Entries snoop the CDB ports, the head entry
// issues to memory once its operands are ready (stores and IO loads only at
// RoB head), and results are broadcast on out_*.
// Optional feature macro: LSQ_DISPATCH_BYPASS_EN (same-cycle CDB capture at dispatch).
module load_store_queue
    import load_store_queue_pkg::*;
#(
    parameter int DEPTH_W = 3,
    parameter int ROB_W   = ROB_SIZE_WIDTH,
    parameter int CDB_N   = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   rdy,
    input  logic                   flush,
    input  logic                   disp_valid,
    input  logic                   disp_store,
    input  logic [2:0]             disp_funct3,
    input  logic [31:0]            disp_imm,
    input  logic [31:0]            disp_v1,
    input  logic [31:0]            disp_v2,
    input  logic                   disp_dep1,
    input  logic                   disp_dep2,
    input  logic [ROB_W-1:0]       disp_q1,
    input  logic [ROB_W-1:0]       disp_q2,
    input  logic [ROB_W-1:0]       disp_rob_id,
    output logic                   full,
    input  logic [CDB_N-1:0]       cdb_valid,
    input  logic [CDB_N*ROB_W-1:0] cdb_rob_id,
    input  logic [CDB_N*32-1:0]    cdb_value,
    input  logic [ROB_W-1:0]       rob_head_id,
    load_store_queue_if.master     mem,
    output logic                   out_valid,
    output logic [ROB_W-1:0]       out_rob_id,
    output logic [31:0]            out_value
);

    localparam int DEPTH = 1 << DEPTH_W;

    typedef struct packed {
        logic             valid;
        logic             store;
        logic [2:0]       funct3;
        logic [31:0]      imm;
        logic [31:0]      v1;
        logic [31:0]      v2;
        logic             dep1;
        logic             dep2;
        logic [ROB_W-1:0] q1;
        logic [ROB_W-1:0] q2;
        logic [ROB_W-1:0] rob_id;
    } entry_t;

    entry_t             ent_q [DEPTH];
    entry_t             ent_d [DEPTH];
    logic [DEPTH_W:0]   head_q, head_d, tail_q, tail_d;
    logic [1:0]         state_q, state_d;
    logic               mem_req_q, mem_req_d, mem_we_q, mem_we_d;
    logic [31:0]        mem_addr_q, mem_addr_d, mem_wdata_q, mem_wdata_d;
    logic [1:0]         mem_size_q, mem_size_d;
    logic               out_valid_q, out_valid_d;
    logic [ROB_W-1:0]   out_rob_id_q, out_rob_id_d;
    logic [31:0]        out_value_q, out_value_d;

    logic [DEPTH_W-1:0] head_idx, tail_idx;
    entry_t             hd;
    logic [31:0]        hd_addr, load_val, store_data;
    logic               hd_ready;

    assign head_idx = head_q[DEPTH_W-1:0];
    assign tail_idx = tail_q[DEPTH_W-1:0];
    assign hd       = ent_q[head_idx];
    assign hd_addr  = hd.v1 + hd.imm;
    // Head may issue: operands present, and either a non-IO load or at RoB head
    assign hd_ready = hd.valid && !hd.dep1 && !hd.dep2 &&
                      ((!hd.store && !is_io(hd_addr[17:16])) || (hd.rob_id == rob_head_id));

    assign full = (state_q == ST_DRAIN) ||
                  ((head_q[DEPTH_W] != tail_q[DEPTH_W]) &&
                   (head_q[DEPTH_W-1:0] == tail_q[DEPTH_W-1:0]));

    load_store_queue_load_align u_align (
        .funct3     (hd.funct3),
        .rdata      (mem.mem_rdata),
        .v2         (hd.v2),
        .load_val   (load_val),
        .store_data (store_data)
    );

    // Next-state: snoop, issue/complete FSM, dispatch, then flush overrides
    always_comb begin
        ent_d        = ent_q;
        head_d       = head_q;
        tail_d       = tail_q;
        state_d      = state_q;
        mem_req_d    = mem_req_q;
        mem_we_d     = mem_we_q;
        mem_addr_d   = mem_addr_q;
        mem_size_d   = mem_size_q;
        mem_wdata_d  = mem_wdata_q;
        out_valid_d  = 1'b0;
        out_rob_id_d = out_rob_id_q;
        out_value_d  = out_value_q;

        // Higher-indexed port is applied last, so it wins on a double match
        if (rdy) begin
            for (int i = 0; i < DEPTH; i++) begin
                for (int p = 0; p < CDB_N; p++) begin
                    if (ent_q[i].valid && cdb_valid[p]) begin
                        if (ent_q[i].dep1 && ent_q[i].q1 == cdb_rob_id[p*ROB_W +: ROB_W]) begin
                            ent_d[i].v1   = cdb_value[p*32 +: 32];
                            ent_d[i].dep1 = 1'b0;
                        end
                        if (ent_q[i].dep2 && ent_q[i].q2 == cdb_rob_id[p*ROB_W +: ROB_W]) begin
                            ent_d[i].v2   = cdb_value[p*32 +: 32];
                            ent_d[i].dep2 = 1'b0;
                        end
                    end
                end
            end
        end

        case (state_q)
            ST_IDLE: begin
                if (rdy && !flush && hd_ready) begin
                    mem_req_d   = 1'b1;
                    mem_we_d    = hd.store;
                    mem_addr_d  = hd_addr;
                    mem_size_d  = hd.funct3[1:0];
                    mem_wdata_d = store_data;
                    state_d     = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (mem.mem_ack) begin
                    mem_req_d              = 1'b0;
                    ent_d[head_idx].valid  = 1'b0;
                    head_d                 = head_q + 1'b1;
                    state_d                = ST_IDLE;
                    if (!flush) begin
                        out_valid_d  = 1'b1;
                        out_rob_id_d = hd.rob_id;
                        out_value_d  = hd.store ? 32'b0 : load_val;
                    end
                end else if (flush) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (mem.mem_ack) begin
                    mem_req_d = 1'b0;
                    state_d   = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (rdy && disp_valid && !full && !flush) begin
            ent_d[tail_idx].valid  = 1'b1;
            ent_d[tail_idx].store  = disp_store;
            ent_d[tail_idx].funct3 = disp_funct3;
            ent_d[tail_idx].imm    = disp_imm;
            ent_d[tail_idx].v1     = disp_v1;
            ent_d[tail_idx].v2     = disp_v2;
            ent_d[tail_idx].dep1   = disp_dep1;
            ent_d[tail_idx].dep2   = disp_dep2;
            ent_d[tail_idx].q1     = disp_q1;
            ent_d[tail_idx].q2     = disp_q2;
            ent_d[tail_idx].rob_id = disp_rob_id;
`ifdef LSQ_DISPATCH_BYPASS_EN
            for (int p = 0; p < CDB_N; p++) begin
                if (cdb_valid[p] && disp_dep1 && disp_q1 == cdb_rob_id[p*ROB_W +: ROB_W]) begin
                    ent_d[tail_idx].v1   = cdb_value[p*32 +: 32];
                    ent_d[tail_idx].dep1 = 1'b0;
                end
                if (cdb_valid[p] && disp_dep2 && disp_q2 == cdb_rob_id[p*ROB_W +: ROB_W]) begin
                    ent_d[tail_idx].v2   = cdb_value[p*32 +: 32];
                    ent_d[tail_idx].dep2 = 1'b0;
                end
            end
`endif
            tail_d = tail_q + 1'b1;
        end

        if (flush) begin
            for (int i = 0; i < DEPTH; i++) begin
                ent_d[i].valid = 1'b0;
            end
            head_d = '0;
            tail_d = '0;
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                ent_q[i] <= '0;
            end
            head_q       <= '0;
            tail_q       <= '0;
            state_q      <= ST_IDLE;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_size_q   <= '0;
            mem_wdata_q  <= '0;
            out_valid_q  <= 1'b0;
            out_rob_id_q <= '0;
            out_value_q  <= '0;
        end else begin
            ent_q        <= ent_d;
            head_q       <= head_d;
            tail_q       <= tail_d;
            state_q      <= state_d;
            mem_req_q    <= mem_req_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_size_q   <= mem_size_d;
            mem_wdata_q  <= mem_wdata_d;
            out_valid_q  <= out_valid_d;
            out_rob_id_q <= out_rob_id_d;
            out_value_q  <= out_value_d;
        end
    end

    assign mem.mem_req   = mem_req_q;
    assign mem.mem_we    = mem_we_q;
    assign mem.mem_addr  = mem_addr_q;
    assign mem.mem_size  = mem_size_q;
    assign mem.mem_wdata = mem_wdata_q;
    assign out_valid     = out_valid_q;
    assign out_rob_id    = out_rob_id_q;
    assign out_value     = out_value_q;

endmodule

// File: tb/tb_load_store_queue.sv
// Directed testbench for load_store_queue (default build, no dispatch bypass).
module tb_load_store_queue;

    logic        clk = 1'b0;
    logic        rst, rdy, flush;
    logic        disp_valid, disp_store, disp_dep1, disp_dep2;
    logic [2:0]  disp_funct3;
    logic [31:0] disp_imm, disp_v1, disp_v2;
    logic [3:0]  disp_q1, disp_q2, disp_rob_id, rob_head_id;
    logic        full;
    logic [1:0]  cdb_valid;
    logic [7:0]  cdb_rob_id;
    logic [63:0] cdb_value;
    logic        out_valid;
    logic [3:0]  out_rob_id;
    logic [31:0] out_value;

    int checks = 0;
    int errors = 0;

    load_store_queue_if mem_bus ();

    load_store_queue dut (
        .clk(clk), .rst(rst), .rdy(rdy), .flush(flush),
        .disp_valid(disp_valid), .disp_store(disp_store), .disp_funct3(disp_funct3),
        .disp_imm(disp_imm), .disp_v1(disp_v1), .disp_v2(disp_v2),
        .disp_dep1(disp_dep1), .disp_dep2(disp_dep2), .disp_q1(disp_q1), .disp_q2(disp_q2),
        .disp_rob_id(disp_rob_id), .full(full),
        .cdb_valid(cdb_valid), .cdb_rob_id(cdb_rob_id), .cdb_value(cdb_value),
        .rob_head_id(rob_head_id), .mem(mem_bus),
        .out_valid(out_valid), .out_rob_id(out_rob_id), .out_value(out_value)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic dispatch(input logic st, input logic [2:0] f3, input logic [31:0] v1,
                            input logic [31:0] imm, input logic [31:0] v2,
                            input logic d1, input logic [3:0] q1, input logic [3:0] rob);
        disp_store = st; disp_funct3 = f3; disp_v1 = v1; disp_imm = imm; disp_v2 = v2;
        disp_dep1 = d1; disp_q1 = q1; disp_dep2 = 1'b0; disp_q2 = 4'd0; disp_rob_id = rob;
        disp_valid = 1'b1;
        step();
        disp_valid = 1'b0;
    endtask

    task automatic wait_req(input string name);
        for (int i = 0; i < 20 && !mem_bus.mem_req; i++) step();
        checks++;
        if (mem_bus.mem_req !== 1'b1) begin
            errors++;
            $display("FAIL %s_req_timeout: mem_req=%b required 1", name, mem_bus.mem_req);
        end
    endtask

    task automatic ack(input logic [31:0] d);
        mem_bus.mem_ack = 1'b1; mem_bus.mem_rdata = d;
        step();
        mem_bus.mem_ack = 1'b0; mem_bus.mem_rdata = 32'h0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) step();
        rst = 1'b0;
        checks++;
        if (mem_bus.mem_req !== 1'b0 || out_valid !== 1'b0 || full !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctrl: req=%b out_valid=%b full=%b required 0 0 0",
                     mem_bus.mem_req, out_valid, full);
        end
        checks++;
        if (out_value !== 32'h0 || out_rob_id !== 4'h0 || mem_bus.mem_addr !== 32'h0) begin
            errors++;
            $display("FAIL reset_data: out_value=%h rob=%h addr=%h required 0", out_value, out_rob_id, mem_bus.mem_addr);
        end
    endtask

    task automatic test_lw();
        dispatch(1'b0, 3'b010, 32'h100, 32'd4, 32'h0, 1'b0, 4'd0, 4'd1);
        wait_req("lw");
        checks++;
        if (mem_bus.mem_addr !== 32'h104 || mem_bus.mem_size !== 2'd2 || mem_bus.mem_we !== 1'b0) begin
            errors++;
            $display("FAIL lw_req: addr=%h size=%0d we=%b required 104 2 0", mem_bus.mem_addr, mem_bus.mem_size, mem_bus.mem_we);
        end
        ack(32'hDEADBEEF);
        checks++;
        if (out_valid !== 1'b1 || out_rob_id !== 4'd1 || out_value !== 32'hDEADBEEF || mem_bus.mem_req !== 1'b0) begin
            errors++;
            $display("FAIL lw_result: valid=%b rob=%0d value=%h req=%b required 1 1 deadbeef 0",
                     out_valid, out_rob_id, out_value, mem_bus.mem_req);
        end
        step();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL lw_pulse: out_valid=%b required 0", out_valid);
        end
    endtask

    task automatic test_extend();
        logic [2:0]  f3  [4] = '{3'b000, 3'b100, 3'b001, 3'b101};
        logic [31:0] rd  [4] = '{32'h12345680, 32'h12345680, 32'hABCD8001, 32'hABCD8001};
        logic [31:0] exp [4] = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF8001, 32'h00008001};
        logic [1:0]  sz  [4] = '{2'd0, 2'd0, 2'd1, 2'd1};
        for (int i = 0; i < 4; i++) begin
            dispatch(1'b0, f3[i], 32'h200, 32'h0, 32'h0, 1'b0, 4'd0, 4'(i + 2));
            wait_req("ext");
            checks++;
            if (mem_bus.mem_size !== sz[i]) begin
                errors++;
                $display("FAIL ext_size[%0d]: size=%0d required %0d", i, mem_bus.mem_size, sz[i]);
            end
            ack(rd[i]);
            checks++;
            if (out_valid !== 1'b1 || out_value !== exp[i]) begin
                errors++;
                $display("FAIL ext_value[%0d]: valid=%b value=%h required 1 %h", i, out_valid, out_value, exp[i]);
            end
        end
    endtask

    task automatic test_store();
        rob_head_id = 4'd4;
        dispatch(1'b1, 3'b010, 32'h40, 32'h0, 32'hCAFEF00D, 1'b0, 4'd0, 4'd5);
        repeat (4) step();
        checks++;
        if (mem_bus.mem_req !== 1'b0) begin
            errors++;
            $display("FAIL sw_not_head: mem_req=%b required 0", mem_bus.mem_req);
        end
        rob_head_id = 4'd5;
        wait_req("sw");
        checks++;
        if (mem_bus.mem_we !== 1'b1 || mem_bus.mem_addr !== 32'h40 || mem_bus.mem_wdata !== 32'hCAFEF00D) begin
            errors++;
            $display("FAIL sw_req: we=%b addr=%h wdata=%h required 1 40 cafef00d",
                     mem_bus.mem_we, mem_bus.mem_addr, mem_bus.mem_wdata);
        end
        ack(32'h0);
        checks++;
        if (out_valid !== 1'b1 || out_rob_id !== 4'd5 || out_value !== 32'h0) begin
            errors++;
            $display("FAIL sw_result: valid=%b rob=%0d value=%h required 1 5 0", out_valid, out_rob_id, out_value);
        end
        rob_head_id = 4'd6;
        dispatch(1'b1, 3'b000, 32'h41, 32'h0, 32'h123456AB, 1'b0, 4'd0, 4'd6);
        wait_req("sb");
        checks++;
        if (mem_bus.mem_wdata !== 32'h000000AB || mem_bus.mem_size !== 2'd0 || mem_bus.mem_addr !== 32'h41) begin
            errors++;
            $display("FAIL sb_req: wdata=%h size=%0d addr=%h required ab 0 41",
                     mem_bus.mem_wdata, mem_bus.mem_size, mem_bus.mem_addr);
        end
        ack(32'h0);
    endtask

    task automatic test_io_load();
        rob_head_id = 4'd6;
        dispatch(1'b0, 3'b010, 32'h00030000, 32'h8, 32'h0, 1'b0, 4'd0, 4'd7);
        repeat (4) step();
        checks++;
        if (mem_bus.mem_req !== 1'b0) begin
            errors++;
            $display("FAIL io_not_head: mem_req=%b required 0", mem_bus.mem_req);
        end
        rob_head_id = 4'd7;
        wait_req("io");
        checks++;
        if (mem_bus.mem_addr !== 32'h00030008) begin
            errors++;
            $display("FAIL io_addr: addr=%h required 00030008", mem_bus.mem_addr);
        end
        ack(32'h55);
    endtask

    task automatic test_cdb();
        dispatch(1'b0, 3'b010, 32'hDEAD, 32'h0, 32'h0, 1'b1, 4'd3, 4'd2);
        repeat (3) step();
        checks++;
        if (mem_bus.mem_req !== 1'b0) begin
            errors++;
            $display("FAIL cdb_wait: mem_req=%b required 0", mem_bus.mem_req);
        end
        cdb_valid  = 2'b11;
        cdb_rob_id = {4'd3, 4'd3};
        cdb_value  = {32'h00000200, 32'h00000300};
        step();
        cdb_valid  = 2'b00;
        wait_req("cdb");
        checks++;
        if (mem_bus.mem_addr !== 32'h200) begin
            errors++;
            $display("FAIL cdb_addr: addr=%h required 200", mem_bus.mem_addr);
        end
        ack(32'h1);
        checks++;
        if (out_valid !== 1'b1 || out_rob_id !== 4'd2) begin
            errors++;
            $display("FAIL cdb_result: valid=%b rob=%0d required 1 2", out_valid, out_rob_id);
        end
    endtask

    task automatic test_fill();
        for (int i = 0; i < 8; i++) begin
            dispatch(1'b0, 3'b010, 32'h1000 + 32'(i * 4), 32'h0, 32'h0, 1'b0, 4'd0, 4'(i));
        end
        checks++;
        if (full !== 1'b1) begin
            errors++;
            $display("FAIL fill_full: full=%b required 1", full);
        end
        dispatch(1'b0, 3'b010, 32'h2000, 32'h0, 32'h0, 1'b0, 4'd0, 4'd8);
        for (int i = 0; i < 8; i++) begin
            wait_req("drain");
            checks++;
            if (mem_bus.mem_addr !== 32'h1000 + 32'(i * 4)) begin
                errors++;
                $display("FAIL drain_addr[%0d]: addr=%h required %h", i, mem_bus.mem_addr, 32'h1000 + 32'(i * 4));
            end
            ack(32'(i * 17));
            checks++;
            if (out_valid !== 1'b1 || out_rob_id !== 4'(i) || out_value !== 32'(i * 17)) begin
                errors++;
                $display("FAIL drain_result[%0d]: valid=%b rob=%0d value=%h", i, out_valid, out_rob_id, out_value);
            end
        end
        repeat (4) step();
        checks++;
        if (mem_bus.mem_req !== 1'b0 || full !== 1'b0) begin
            errors++;
            $display("FAIL drain_empty: req=%b full=%b required 0 0", mem_bus.mem_req, full);
        end
        dispatch(1'b0, 3'b010, 32'h3000, 32'h0, 32'h0, 1'b0, 4'd0, 4'd9);
        wait_req("wrap");
        checks++;
        if (mem_bus.mem_addr !== 32'h3000) begin
            errors++;
            $display("FAIL wrap_addr: addr=%h required 3000", mem_bus.mem_addr);
        end
        ack(32'h0);
    endtask

    task automatic test_flush();
        dispatch(1'b0, 3'b010, 32'h500, 32'h0, 32'h0, 1'b0, 4'd0, 4'd10);
        dispatch(1'b0, 3'b010, 32'h600, 32'h0, 32'h0, 1'b0, 4'd0, 4'd11);
        wait_req("flush");
        flush = 1'b1;
        step();
        flush = 1'b0;
        checks++;
        if (full !== 1'b1 || mem_bus.mem_req !== 1'b1) begin
            errors++;
            $display("FAIL flush_drain: full=%b req=%b required 1 1", full, mem_bus.mem_req);
        end
        repeat (3) step();
        checks++;
        if (full !== 1'b1) begin
            errors++;
            $display("FAIL flush_hold: full=%b required 1", full);
        end
        ack(32'h77);
        checks++;
        if (out_valid !== 1'b0 || mem_bus.mem_req !== 1'b0 || full !== 1'b0) begin
            errors++;
            $display("FAIL flush_ack: out_valid=%b req=%b full=%b required 0 0 0", out_valid, mem_bus.mem_req, full);
        end
        repeat (5) step();
        checks++;
        if (mem_bus.mem_req !== 1'b0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL flush_empty: req=%b out_valid=%b required 0 0", mem_bus.mem_req, out_valid);
        end
        flush = 1'b1;
        dispatch(1'b0, 3'b010, 32'h700, 32'h0, 32'h0, 1'b0, 4'd0, 4'd12);
        flush = 1'b0;
        repeat (5) step();
        checks++;
        if (mem_bus.mem_req !== 1'b0) begin
            errors++;
            $display("FAIL flush_disp: req=%b required 0", mem_bus.mem_req);
        end
    endtask

    initial begin
        rst = 1'b1; rdy = 1'b1; flush = 1'b0;
        disp_valid = 1'b0; disp_store = 1'b0; disp_funct3 = 3'b0; disp_imm = '0;
        disp_v1 = '0; disp_v2 = '0; disp_dep1 = 1'b0; disp_dep2 = 1'b0;
        disp_q1 = '0; disp_q2 = '0; disp_rob_id = '0; rob_head_id = '0;
        cdb_valid = '0; cdb_rob_id = '0; cdb_value = '0;
        mem_bus.mem_ack = 1'b0; mem_bus.mem_rdata = '0;
        test_reset();
        test_lw();
        test_extend();
        test_store();
        test_io_load();
        test_cdb();
        test_fill();
        test_flush();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
